// File: rtl/decoder_onehot_scan.sv
// decoder_onehot_scan: registered binary-to-one-hot decoder with two modes.
// In DIRECT mode it decodes each accepted code. In SCAN mode it walks a single
// strobe across every output position.
// Optional feature: define DECODER_MASK_EN to add an i_mask port that gates
// individual output positions. Masked slots still take their scan time.
module decoder_onehot_scan #(
    parameter int IN_W     = 3,
    parameter int SCAN_DIV = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic                   i_mode,
    input  logic [IN_W-1:0]        i_sel,
    input  logic                   i_sel_valid,
`ifdef DECODER_MASK_EN
    input  logic [(1<<IN_W)-1:0]   i_mask,
`endif
    output logic                   o_sel_ready,
    output logic [(1<<IN_W)-1:0]   o_onehot,
    output logic [IN_W-1:0]        o_idx,
    output logic                   o_wrap
);

    localparam int OUT_W = 1 << IN_W;
    localparam int PW    = $clog2(SCAN_DIV) + 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IN_W-1:0] r_idx;
    logic [IN_W-1:0] w_idx_nxt;
    logic [PW-1:0]   r_presc;
    logic [PW-1:0]   w_presc_nxt;
    logic            w_wrap_nxt;
    logic [OUT_W-1:0] w_onehot_nxt;
    logic [OUT_W-1:0] w_mask;
    logic            w_accept;

    // Binary index to a single-bit position.
    function automatic logic [OUT_W-1:0] decode_pos(input logic [IN_W-1:0] code);
        decode_pos = {{(OUT_W-1){1'b0}}, 1'b1} << code;
    endfunction

`ifdef DECODER_MASK_EN
    assign w_mask = i_mask;
`else
    assign w_mask = {OUT_W{1'b1}};
`endif

    // A code is only taken in DIRECT-capable operation, never while scanning or held off.
    assign o_sel_ready = i_en & ~i_mode & ~i_rst;
    assign w_accept    = i_sel_valid & o_sel_ready;

    // Next-state, next-index, prescaler and wrap pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_presc_nxt = r_presc;
        w_wrap_nxt  = 1'b0;
        if (!i_en) begin
            // Disabled: everything frozen, nothing accepted.
            w_state_nxt = r_state;
            w_idx_nxt   = r_idx;
            w_presc_nxt = r_presc;
        end else if (i_mode && (r_state != ST_SCAN)) begin
            // Scan entry always restarts at position 0 with a fresh prescaler.
            w_state_nxt = ST_SCAN;
            w_idx_nxt   = {IN_W{1'b0}};
            w_presc_nxt = {PW{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = ST_DIRECT;
                        w_idx_nxt   = i_sel;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_DIRECT: begin
                    if (w_accept) begin
                        w_idx_nxt = i_sel;
                    end else begin
                        w_idx_nxt = r_idx;
                    end
                end
                ST_SCAN: begin
                    if (!i_mode) begin
                        // Leave scan holding the current position unless a code arrives now.
                        w_state_nxt = ST_DIRECT;
                        if (w_accept) begin
                            w_idx_nxt = i_sel;
                        end else begin
                            w_idx_nxt = r_idx;
                        end
                    end else if (r_presc == PRESC_LAST) begin
                        w_presc_nxt = {PW{1'b0}};
                        w_idx_nxt   = r_idx + {{(IN_W-1){1'b0}}, 1'b1};
                        w_wrap_nxt  = (r_idx == {IN_W{1'b1}});
                    end else begin
                        w_presc_nxt = r_presc + {{(PW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = {IN_W{1'b0}};
                    w_presc_nxt = {PW{1'b0}};
                end
            endcase
        end
    end

    // Output is the decoded next index, blanked when idle or disabled.
    always_comb begin
        if (i_en && (w_state_nxt != ST_IDLE)) begin
            w_onehot_nxt = decode_pos(w_idx_nxt) & w_mask;
        end else begin
            w_onehot_nxt = {OUT_W{1'b0}};
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_idx    <= {IN_W{1'b0}};
            r_presc  <= {PW{1'b0}};
            o_onehot <= {OUT_W{1'b0}};
            o_wrap   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_presc  <= w_presc_nxt;
            o_onehot <= w_onehot_nxt;
            o_wrap   <= w_wrap_nxt;
        end
    end

    assign o_idx = r_idx;

endmodule
